// File: rtl/wb_pkg.sv
// Shared types and load encodings for the writeback retirement queue.
// Entry layout is fixed to a 32-bit datapath with 5-bit register addresses.
package wb_pkg;

    localparam int WB_XLEN   = 32;
    localparam int WB_REG_AW = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [WB_REG_AW-1:0] rd;
        logic [WB_XLEN-1:0]   data;
        logic                 is_load;
        logic [2:0]           funct3;
        logic [1:0]           addr_lo;
        logic                 done;
    } wb_entry_t;

    // Undefined funct3 codes behave as LW, so they also need word alignment.
    function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            F3_LB, F3_LBU: mis = 1'b0;
            F3_LH, F3_LHU: mis = addr_lo[0];
            default:       mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load-data extraction: selects byte/halfword from the raw word
// and sign- or zero-extends it; also reports misalignment.
module wb_load_align
    import wb_pkg::*;
(
    input  logic [2:0]         funct3,
    input  logic [1:0]         addr_lo,
    input  logic [WB_XLEN-1:0] word,
    output logic [WB_XLEN-1:0] data,
    output logic               misalign
);

    logic [4:0]  byte_sel;
    logic [4:0]  half_sel;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign byte_sel = {addr_lo, 3'b000};
    assign half_sel = {addr_lo[1], 4'b0000};
    assign byte_val = word[byte_sel +: 8];
    assign half_val = word[half_sel +: 16];
    assign misalign = load_misaligned(funct3, addr_lo);

    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{24{byte_val[7]}}, byte_val};
            F3_LH:   data = {{16{half_val[15]}}, half_val};
            F3_LBU:  data = {24'h000000, byte_val};
            F3_LHU:  data = {16'h0000, half_val};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/wb_retire_queue.sv
// In-order writeback retirement queue: ALU results and load responses retire
// to the register-file write port strictly in program order.
module wb_retire_queue
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_is_load,
    input  logic [REG_AW-1:0]        in_rd,
    input  logic [XLEN-1:0]          in_data,
    input  logic [2:0]               in_funct3,
    input  logic [1:0]               in_addr_lo,
    input  logic                     mem_done,
    input  logic [XLEN-1:0]          mem_rdata,
    output logic                     wb_en,
    output logic [REG_AW-1:0]        wb_rd,
    output logic [XLEN-1:0]          wb_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_unexp_rsp,
    output logic                     err_misalign
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         q [DEPTH];
    wb_entry_t         head_e;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     ld_ptr;
    logic [PW-1:0]     ld_ptr_nx;
    logic [PW-1:0]     off_ld;
    logic [PW-1:0]     nxt_idx;
    logic              ld_valid;
    logic              ld_valid_nx;
    logic              nxt_found;
    logic              enq;
    logic              deq;
    logic              rsp_hit;
    logic [XLEN-1:0]   ld_data;
    logic              ld_mis;

    assign in_ready = (count < CW'(DEPTH));
    assign enq      = in_valid && in_ready;
    assign head_e   = q[head];
    assign deq      = (count != '0) && head_e.done;
    assign rsp_hit  = mem_done && ld_valid;

    wb_load_align u_align (
        .funct3   (head_e.funct3),
        .addr_lo  (head_e.addr_lo),
        .word     (head_e.data),
        .data     (ld_data),
        .misalign (ld_mis)
    );

    // Loads are answered oldest-first, so every load younger than ld_ptr is
    // still waiting; the next target is simply the next load in age order.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = ld_ptr;
        off_ld    = ld_ptr - head;
        for (int j = 1; j < DEPTH; j++) begin
            if (!nxt_found && (j > int'(off_ld)) && (j < int'(count))) begin
                if (q[head + PW'(j)].is_load && !q[head + PW'(j)].done) begin
                    nxt_found = 1'b1;
                    nxt_idx   = head + PW'(j);
                end
            end
        end
    end

    always_comb begin
        ld_ptr_nx   = ld_ptr;
        ld_valid_nx = ld_valid;
        if (rsp_hit) begin
            if (nxt_found) begin
                ld_ptr_nx = nxt_idx;
            end else begin
                ld_valid_nx = 1'b0;
            end
        end
        if (enq && in_is_load && !ld_valid_nx) begin
            ld_ptr_nx   = tail;
            ld_valid_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
            head          <= '0;
            tail          <= '0;
            ld_ptr        <= '0;
            ld_valid      <= 1'b0;
            count         <= '0;
            wb_en         <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            err_unexp_rsp <= 1'b0;
            err_misalign  <= 1'b0;
        end else begin
            if (enq) begin
                q[tail].rd      <= in_rd;
                q[tail].data    <= in_is_load ? '0 : in_data;
                q[tail].is_load <= in_is_load;
                q[tail].funct3  <= in_funct3;
                q[tail].addr_lo <= in_addr_lo;
                q[tail].done    <= !in_is_load;
                tail            <= tail + PW'(1);
                if (in_is_load && load_misaligned(in_funct3, in_addr_lo)) begin
                    err_misalign <= 1'b1;
                end
            end

            if (rsp_hit) begin
                q[ld_ptr].data <= mem_rdata;
                q[ld_ptr].done <= 1'b1;
            end
            if (mem_done && !ld_valid) begin
                err_unexp_rsp <= 1'b1;
            end
            ld_ptr   <= ld_ptr_nx;
            ld_valid <= ld_valid_nx;

            if (deq) begin
                head    <= head + PW'(1);
                wb_en   <= (head_e.rd != '0);
                wb_rd   <= head_e.rd;
                if (head_e.is_load) begin
                    wb_data <= ld_mis ? '0 : ld_data;
                end else begin
                    wb_data <= head_e.data;
                end
            end else begin
                wb_en <= 1'b0;
            end

            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Self-checking bench for wb_retire_queue: expected writebacks are queued at
// enqueue time and compared as the DUT strobes wb_en.
module tb_wb_retire_queue;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_is_load = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_data = '0;
    logic [2:0]  in_funct3 = '0;
    logic [1:0]  in_addr_lo = '0;
    logic        mem_done = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [2:0]  count;
    logic        err_unexp_rsp;
    logic        err_misalign;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    wb_retire_queue #(.XLEN(32), .REG_AW(5), .DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_is_load    (in_is_load),
        .in_rd         (in_rd),
        .in_data       (in_data),
        .in_funct3     (in_funct3),
        .in_addr_lo    (in_addr_lo),
        .mem_done      (mem_done),
        .mem_rdata     (mem_rdata),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .count         (count),
        .err_unexp_rsp (err_unexp_rsp),
        .err_misalign  (err_misalign)
    );

    always #5 clk = ~clk;

    // Scoreboard: every register write must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && wb_en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h, required no write", wb_rd, wb_data);
            end else begin
                e = sb.pop_front();
                if (wb_rd !== e.rd || wb_data !== e.data) begin
                    errors++;
                    $display("FAIL wb_order: got rd=%0d data=%h, required rd=%0d data=%h",
                             wb_rd, wb_data, e.rd, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        in_valid = 1'b0;
        mem_done = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic enq(input bit ld, input logic [4:0] rd, input logic [31:0] d,
                       input logic [2:0] f3, input logic [1:0] alo,
                       input bit push, input logic [31:0] exp_data);
        exp_t e;
        in_valid   = 1'b1;
        in_is_load = ld;
        in_rd      = rd;
        in_data    = d;
        in_funct3  = f3;
        in_addr_lo = alo;
        if (push && in_ready && rd != 5'd0) begin
            e.rd   = rd;
            e.data = exp_data;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic rsp(input logic [31:0] word);
        mem_done  = 1'b1;
        mem_rdata = word;
        @(posedge clk);
        #1 mem_done = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || count != 3'd0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || count !== 3'd0) begin
            errors++;
            $display("FAIL %s_drain: pending=%0d count=%0d, required 0 and 0", name, sb.size(), count);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (wb_en !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 || count !== 3'd0 ||
            in_ready !== 1'b1 || err_unexp_rsp !== 1'b0 || err_misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: en=%b rd=%0d data=%h count=%0d ready=%b unexp=%b mis=%b, required 0 0 0 0 1 0 0",
                     wb_en, wb_rd, wb_data, count, in_ready, err_unexp_rsp, err_misalign);
        end
        // Traffic that the reset below must discard, including a misaligned LW.
        enq(1'b1, 5'd6, 32'd0, F3_LW, 2'd1, 1'b0, 32'd0);
        enq(1'b1, 5'd7, 32'd0, F3_LB, 2'd0, 1'b0, 32'd0);
        enq(1'b0, 5'd8, 32'h1111, F3_LW, 2'd0, 1'b0, 32'd0);
        @(negedge clk);
        checks++;
        if (count !== 3'd3 || err_misalign !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre: count=%0d mis=%b, required 3 and 1", count, err_misalign);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (wb_en !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 ||
            err_unexp_rsp !== 1'b0 || err_misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: en=%b count=%0d ready=%b unexp=%b mis=%b, required 0 0 1 0 0",
                     wb_en, count, in_ready, err_unexp_rsp, err_misalign);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        rsp(32'h12345678);
        repeat (3) @(negedge clk);
        checks++;
        if (err_unexp_rsp !== 1'b1 || count !== 3'd0) begin
            errors++;
            $display("FAIL reset_unexp: unexp=%b count=%0d, required 1 and 0", err_unexp_rsp, count);
        end
    endtask

    task automatic test_alu();
        do_reset();
        enq(1'b0, 5'd5, 32'h00001234, F3_LW, 2'd0, 1'b1, 32'h00001234);
        @(negedge clk);
        checks++;
        if (wb_en !== 1'b0) begin
            errors++;
            $display("FAIL alu_early: wb_en=%b, required 0", wb_en);
        end
        @(negedge clk);
        checks++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h00001234) begin
            errors++;
            $display("FAIL alu_latency: en=%b rd=%0d data=%h, required 1 5 00001234", wb_en, wb_rd, wb_data);
        end
        @(negedge clk);
        checks++;
        if (wb_en !== 1'b0 || wb_rd !== 5'd5 || wb_data !== 32'h00001234) begin
            errors++;
            $display("FAIL alu_pulse: en=%b rd=%0d data=%h, required 0 with held 5 00001234", wb_en, wb_rd, wb_data);
        end
        drain("alu");
    endtask

    task automatic test_load_then_alu();
        do_reset();
        enq(1'b1, 5'd3, 32'd0, F3_LB, 2'd2, 1'b1, 32'hFFFFFF80);
        enq(1'b0, 5'd4, 32'h000000AA, F3_LW, 2'd0, 1'b1, 32'h000000AA);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (wb_en !== 1'b0) begin
                errors++;
                $display("FAIL ld_block: cycle %0d wb_en=%b rd=%0d, required 0", i, wb_en, wb_rd);
            end
        end
        rsp(32'h00800000);
        @(negedge clk);
        checks++;
        if (wb_en !== 1'b0) begin
            errors++;
            $display("FAIL ld_capture: wb_en=%b, required 0", wb_en);
        end
        @(negedge clk);
        checks++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL ld_retire: en=%b rd=%0d data=%h, required 1 3 ffffff80", wb_en, wb_rd, wb_data);
        end
        @(negedge clk);
        checks++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 32'h000000AA) begin
            errors++;
            $display("FAIL ld_then_alu: en=%b rd=%0d data=%h, required 1 4 000000aa", wb_en, wb_rd, wb_data);
        end
        drain("ld_alu");
    endtask

    task automatic test_full();
        do_reset();
        enq(1'b1, 5'd10, 32'd0, F3_LHU, 2'd0, 1'b1, 32'h0000BEEF);
        enq(1'b1, 5'd11, 32'd0, F3_LW,  2'd0, 1'b1, 32'h12345678);
        enq(1'b1, 5'd12, 32'd0, F3_LH,  2'd2, 1'b1, 32'hFFFF8001);
        enq(1'b1, 5'd13, 32'd0, F3_LBU, 2'd3, 1'b1, 32'h000000F0);
        @(negedge clk);
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state: count=%0d ready=%b, required 4 and 0", count, in_ready);
        end
        enq(1'b0, 5'd20, 32'h55555555, F3_LW, 2'd0, 1'b1, 32'h55555555);
        @(negedge clk);
        checks++;
        if (count !== 3'd4 || err_misalign !== 1'b0 || err_unexp_rsp !== 1'b0) begin
            errors++;
            $display("FAIL full_drop: count=%0d mis=%b unexp=%b, required 4 0 0", count, err_misalign, err_unexp_rsp);
        end
        rsp(32'h0000BEEF);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd10 || wb_data !== 32'h0000BEEF || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_first: en=%b rd=%0d data=%h ready=%b, required 1 10 0000beef 1",
                     wb_en, wb_rd, wb_data, in_ready);
        end
        rsp(32'h12345678);
        rsp(32'h80010000);
        rsp(32'hF0000000);
        drain("full");
    endtask

    task automatic test_x0_misalign();
        do_reset();
        enq(1'b0, 5'd0, 32'hDEADBEEF, F3_LW, 2'd0, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if (count !== 3'd1) begin
            errors++;
            $display("FAIL x0_enq: count=%0d, required 1", count);
        end
        @(negedge clk);
        checks++;
        if (count !== 3'd0 || wb_en !== 1'b0) begin
            errors++;
            $display("FAIL x0_retire: count=%0d wb_en=%b, required 0 and 0", count, wb_en);
        end
        enq(1'b1, 5'd7, 32'd0, F3_LH, 2'd1, 1'b1, 32'h00000000);
        @(negedge clk);
        checks++;
        if (err_misalign !== 1'b1) begin
            errors++;
            $display("FAIL misalign_flag: err_misalign=%b, required 1", err_misalign);
        end
        rsp(32'hFFFFFFFF);
        drain("misalign");
    endtask

    task automatic test_simul_load_rsp();
        exp_t e;
        do_reset();
        enq(1'b1, 5'd20, 32'd0, F3_LW, 2'd0, 1'b1, 32'hCAFEF00D);
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_rd      = 5'd21;
        in_funct3  = F3_LBU;
        in_addr_lo = 2'd1;
        e.rd   = 5'd21;
        e.data = 32'h000000AB;
        sb.push_back(e);
        mem_done  = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mem_done = 1'b0;
        rsp(32'h0000AB00);
        drain("simul");
        checks++;
        if (err_unexp_rsp !== 1'b0) begin
            errors++;
            $display("FAIL simul_ldptr: err_unexp_rsp=%b, required 0", err_unexp_rsp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int run;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            enq(1'b0, 5'(i + 1), d, F3_LW, 2'd0, 1'b1, d);
        end
        // A steady one-per-cycle stream should never let the queue grow past 1.
        @(negedge clk);
        checks++;
        if (count > 3'd1) begin
            errors++;
            $display("FAIL b2b_count: count=%0d, required at most 1", count);
        end
        drain("b2b");
        run = 0;
        checks++;
        if (sb.size() != run) begin
            errors++;
            $display("FAIL b2b_left: pending=%0d, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_then_alu();
        test_full();
        test_x0_misalign();
        test_simul_load_rsp();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
